// File: rtl/fpu_pkg.sv
// Shared types for the FPU sharing logic: result status codes, arbiter states, operand field layout.
package fpu_pkg;

  typedef enum logic [3:0] {
    OVERFLOW  = 4'd0,
    UNDERFLOW = 4'd1,
    EXACT     = 4'd2,
    INEXACT   = 4'd3
  } status_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  // Operand word: sign[31], exp[30:21], mant[20:0]
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 21;
  localparam int MANT_W   = 21;

endpackage

// File: rtl/fpu_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after last_grant+1 (mod N_REQ).
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [IW-1:0]    grant_idx,
  output logic             any
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    cand         = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(last_grant) + i) % N_REQ);
      if (!found && req[cand]) begin
        found              = 1'b1;
        grant_idx          = cand;
        grant_onehot[cand] = 1'b1;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin sequencer sharing one FPU adder core; one operation in flight, response L+2 cycles after accept.
// Optional WAIT timeout abort is built in when FPU_ARB_TIMEOUT_EN is defined.
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clock_100Khz,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0][31:0] req_a,
  input  logic [N_REQ-1:0][31:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_data,
  output status_t               rsp_status,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [31:0]           fpu_op_a,
  output logic [31:0]           fpu_op_b,
  output logic                  fpu_start,
  input  logic                  fpu_done,
  input  logic [31:0]           fpu_data,
  input  logic [3:0]            fpu_status
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t      state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   grant_q;
  logic [N_REQ-1:0] grant_onehot;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req          (req_valid),
    .last_grant   (last_grant),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  // Accept is only offered in IDLE and never while reset is held.
  assign req_ready = (state == IDLE && reset) ? grant_onehot : '0;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT > 0);
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= IW'(N_REQ - 1);
      grant_q    <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_status <= EXACT;
      busy       <= 1'b0;
      fpu_op_a   <= '0;
      fpu_op_b   <= '0;
      fpu_start  <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
      rsp_err    <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            fpu_op_a  <= req_a[grant_idx];
            fpu_op_b  <= req_b[grant_idx];
            grant_q   <= grant_idx;
            fpu_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          fpu_start <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
          state     <= WAIT;
        end
        WAIT: begin
          if (fpu_done) begin
            rsp_data   <= fpu_data;
            rsp_status <= status_t'(fpu_status);
            rsp_valid  <= N_REQ'(1) << grant_q;
`ifdef FPU_ARB_TIMEOUT_EN
            rsp_err    <= 1'b0;
`endif
            state      <= RESPOND;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          // Abort: a zero/OVERFLOW result flagged with rsp_err frees the core for others.
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_data   <= '0;
            rsp_status <= OVERFLOW;
            rsp_err    <= 1'b1;
            rsp_valid  <= N_REQ'(1) << grant_q;
            state      <= RESPOND;
          end else begin
            wait_cnt   <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESPOND: begin
          rsp_valid  <= '0;
          last_grant <= grant_q;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: behavioural L=5 core, scoreboard of expected responses keyed at accept time.
module tb_fpu_arbiter;
  import fpu_pkg::*;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 8;
  localparam int L       = 5;

  logic                   clock_100Khz;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0][31:0] req_a;
  logic [N_REQ-1:0][31:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [31:0]            rsp_data;
  status_t                rsp_status;
  logic                   rsp_err;
  logic                   busy;
  logic [31:0]            fpu_op_a;
  logic [31:0]            fpu_op_b;
  logic                   fpu_start;
  logic                   fpu_done;
  logic [31:0]            fpu_data;
  logic [3:0]             fpu_status;

  logic model_done, spur_done, core_mute, timeout_mode;
  assign fpu_done = model_done | spur_done;

  fpu_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clock_100Khz (clock_100Khz),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_status   (rsp_status),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .fpu_op_a     (fpu_op_a),
    .fpu_op_b     (fpu_op_b),
    .fpu_start    (fpu_start),
    .fpu_done     (fpu_done),
    .fpu_data     (fpu_data),
    .fpu_status   (fpu_status)
  );

  initial clock_100Khz = 1'b0;
  always #5 clock_100Khz = ~clock_100Khz;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Positive-operand adder model: returns {status, result}.
  function automatic logic [35:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [9:0]  ea, eb, et;
    logic [22:0] ma, mb, mt, sum;
    logic        lost;
    int          d;
    ea = a[EXP_MSB:EXP_LSB];
    eb = b[EXP_MSB:EXP_LSB];
    ma = {2'b01, a[MANT_W-1:0]};
    mb = {2'b01, b[MANT_W-1:0]};
    if (eb > ea) begin
      et = ea; ea = eb; eb = et;
      mt = ma; ma = mb; mb = mt;
    end
    d = int'(ea) - int'(eb);
    if (d >= 23) begin
      lost = (mb != 0);
      mb   = '0;
    end else begin
      lost = ((mb & ((23'd1 << d) - 23'd1)) != 0);
      mb   = mb >> d;
    end
    sum = ma + mb;
    if (sum[22]) begin
      lost = lost | sum[0];
      sum  = sum >> 1;
      ea   = ea + 10'd1;
    end
    fp_add = {(lost ? INEXACT : EXACT), a[SIGN_BIT], ea, sum[MANT_W-1:0]};
  endfunction

  // Core model: done L cycles after the start cycle, operands read on the done cycle.
  int core_cnt = 0;
  always @(negedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      core_cnt   = 0;
      model_done = 1'b0;
    end else begin
      logic [35:0] r;
      model_done = 1'b0;
      fpu_data   = 32'hDEAD_BEEF;
      fpu_status = 4'hF;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0 && !core_mute) begin
          r          = fp_add(fpu_op_a, fpu_op_b);
          model_done = 1'b1;
          fpu_data   = r[31:0];
          fpu_status = r[35:32];
        end
      end
      if (fpu_start) core_cnt = L;
    end
  end

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [3:0]  st;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   model_last = N_REQ - 1;

  function automatic int rr_expect(input logic [N_REQ-1:0] v, input int last);
    for (int i = 1; i <= N_REQ; i++)
      if (v[(last + i) % N_REQ]) return (last + i) % N_REQ;
    return -1;
  endfunction

  // Scoreboard monitor: push on accept, pop and compare on response.
  always @(negedge clock_100Khz) begin
    #2;
    if (reset) begin
      if (req_ready != 0) begin
        exp_t        e;
        int          g;
        logic [35:0] r;
        g = rr_expect(req_valid, model_last);
        check("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        if (g >= 0) begin
          r     = fp_add(req_a[g], req_b[g]);
          e.idx = g;
          e.data = timeout_mode ? 32'd0 : r[31:0];
          e.st   = timeout_mode ? OVERFLOW : r[35:32];
          e.err  = timeout_mode;
          sb.push_back(e);
        end
      end
      if (rsp_valid != 0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_onehot", 32'(rsp_valid), 32'd1 << e.idx);
          check("rsp_data", rsp_data, e.data);
          check("rsp_status", 32'(rsp_status), 32'(e.st));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          model_last = e.idx;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_fpu_start"}, 32'(fpu_start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_op_a"}, fpu_op_a, 32'd0);
    check({tag, "_op_b"}, fpu_op_b, 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_rsp_status"}, 32'(rsp_status), 32'(EXACT));
  endtask

  // Request from one requester; inputs are scrambled after accept.
  task automatic do_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input bit spur_issue, input int max_lat,
                        output logic start_t1, output logic busy_t1, output int lat);
    int k;
    @(negedge clock_100Khz);
    req_valid[idx] = 1'b1;
    req_a[idx]     = a;
    req_b[idx]     = b;
    k = 0;
    #1;
    while (!req_ready[idx] && k < 50) begin
      @(negedge clock_100Khz);
      #1;
      k++;
    end
    check("accept_seen", 32'(req_ready[idx]), 32'd1);
    @(negedge clock_100Khz);
    req_valid[idx] = 1'b0;
    req_a[idx]     = a ^ 32'h0015_5555;
    req_b[idx]     = b ^ 32'h000A_AAAA;
    start_t1 = fpu_start;
    busy_t1  = busy;
    if (spur_issue) spur_done = 1'b1;
    lat = 1;
    while (!rsp_valid[idx] && lat < max_lat) begin
      @(negedge clock_100Khz);
      spur_done = 1'b0;
      lat++;
    end
    spur_done = 1'b0;
  endtask

  initial begin
    logic st1, bz1;
    int   lat, n, k, cnt;

    reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    spur_done = 1'b0; core_mute = 1'b0; timeout_mode = 1'b0;
    repeat (3) @(negedge clock_100Khz);
    #1;
    check_reset_outputs("reset");
    @(negedge clock_100Khz);
    reset = 1'b1;

    // Single request, 1.0 + 1.0
    do_req(0, 32'h3FE0_0000, 32'h3FE0_0000, 1'b0, 40, st1, bz1, lat);
    check("t1_start", 32'(st1), 32'd1);
    check("t1_busy", 32'(bz1), 32'd1);
    check("t1_latency", lat, 7);
    check("t1_data", rsp_data, 32'h4000_0000);

    // Spurious done while idle
    @(negedge clock_100Khz);
    spur_done = 1'b1;
    @(negedge clock_100Khz);
    spur_done = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clock_100Khz);
      if (busy || fpu_start || rsp_valid != 0) cnt++;
    end
    check("spur_idle_activity", cnt, 0);
    check("spur_idle_hold_data", rsp_data, 32'h4000_0000);

    // Operand stability with inexact result
    do_req(1, 32'h4010_0001, 32'h3FE0_0003, 1'b0, 40, st1, bz1, lat);
    check("stab_latency", lat, 7);

    // Spurious done during ISSUE
    do_req(2, 32'h3FF0_0000, 32'h3FE8_0000, 1'b1, 40, st1, bz1, lat);
    check("spur_issue_latency", lat, 7);

    // Reset asserted two cycles after fpu_start
    @(negedge clock_100Khz);
    req_valid[3] = 1'b1; req_a[3] = 32'h3FE0_1234; req_b[3] = 32'h3FE0_4321;
    k = 0;
    #1;
    while (!req_ready[3] && k < 50) begin
      @(negedge clock_100Khz);
      #1;
      k++;
    end
    check("rst_accept_seen", 32'(req_ready[3]), 32'd1);
    @(negedge clock_100Khz);
    req_valid[3] = 1'b0;
    repeat (2) @(negedge clock_100Khz);
    reset = 1'b0;
    sb.delete();
    model_last = N_REQ - 1;
    #1;
    check_reset_outputs("midwait");
    repeat (2) @(negedge clock_100Khz);
    reset = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clock_100Khz);
      if (rsp_valid != 0) cnt++;
    end
    check("no_rsp_after_reset", cnt, 0);

    // Fairness: all valid for 8 operations, requester 0 first
    @(negedge clock_100Khz);
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i] = {1'b0, 10'($urandom_range(505, 515)), 21'($urandom)};
      req_b[i] = {1'b0, 10'($urandom_range(505, 515)), 21'($urandom)};
    end
    req_valid = '1;
    #1;
    check("fair_first_grant", 32'(req_ready), 32'd1);
    n = 0; k = 0;
    while (n < 8 && k < 200) begin
      @(negedge clock_100Khz);
      k++;
      if (rsp_valid != 0) begin
        check("fair_order", 32'(rsp_valid), 32'd1 << (n % N_REQ));
        n++;
        if (n == 8) req_valid = '0;
      end
    end
    req_valid = '0;
    check("fair_count", n, 8);

`ifdef FPU_ARB_TIMEOUT_EN
    // Timeout: core never answers, then a late done arrives
    core_mute = 1'b1;
    timeout_mode = 1'b1;
    do_req(1, 32'h3FE0_0000, 32'h3FE0_0000, 1'b0, 60, st1, bz1, lat);
    check("to_latency", lat, TIMEOUT + 2);
    timeout_mode = 1'b0;
    repeat (2) @(negedge clock_100Khz);
    spur_done = 1'b1;
    @(negedge clock_100Khz);
    spur_done = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clock_100Khz);
      if (busy || rsp_valid != 0) cnt++;
    end
    check("to_late_done_ignored", cnt, 0);
    check("to_hold_err", 32'(rsp_err), 32'd1);
    check("to_hold_data", rsp_data, 32'd0);
    core_mute = 1'b0;
`endif

    repeat (5) @(negedge clock_100Khz);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Round-robin arbiter and sequencer that shares one FPU adder core between `N_REQ` requesters. It accepts one operand pair at a time and drives the core with a one-cycle start pulse. It then waits for the core's done, captures the result and status, and returns them to the granted requester with a one-cycle response strobe. It sits between the client blocks and the FPU core, and it is the only block that drives the core's operand inputs.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 64: maximum cycles spent in WAIT before the operation is aborted (active only with the timeout feature).

Ports:
- `clock_100Khz`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request. Must be held until the matching `req_ready`.
- `req_a`  in  N_REQ×32  operand A per requester: sign[31], exp[30:21], mant[20:0].
- `req_b`  in  N_REQ×32  operand B per requester, same format.
- `req_ready`  out  N_REQ  one-hot accept pulse; the request transfers on this edge.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle result strobe to the granted requester.
- `rsp_data`  out  32  result word.
- `rsp_status`  out  4  `status_t` (OVERFLOW=0, UNDERFLOW=1, EXACT=2, INEXACT=3).
- `rsp_err`  out  1  result aborted by timeout; qualified by `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `fpu_op_a`  out  32  operand A to the core.
- `fpu_op_b`  out  32  operand B to the core.
- `fpu_start`  out  1  one-cycle start pulse to the core.
- `fpu_done`  in  1  core result valid, one cycle.
- `fpu_data`  in  32  core result.
- `fpu_status`  in  4  core status.

## Operation
- FSM states and transitions: IDLE → ISSUE → WAIT → RESPOND → IDLE.
- **IDLE:**
  - If any `req_valid` is high, the grant goes to the first requester at or after `last_grant+1` (mod N_REQ).
  - `req_ready[g]` is driven combinationally in this cycle.
  - On the edge, `req_a[g]`/`req_b[g]` are registered into `fpu_op_a`/`fpu_op_b`, `g` is stored, and the FSM moves to ISSUE.
- **ISSUE:** `fpu_start`=1 for exactly this cycle. Move to WAIT and clear the wait counter.
- **WAIT:**
  - `fpu_done` is sampled only in this state.
  - On done, capture `fpu_data`/`fpu_status` into `rsp_data`/`rsp_status`, set `rsp_err`=0, and move to RESPOND.
  - Otherwise, increment the counter.
- **RESPOND:** `rsp_valid[g]`=1 for one cycle. Set `last_grant`=g and return to IDLE.
- Operands stay stable on `fpu_op_a`/`fpu_op_b` from ISSUE until the next IDLE accept. The core may sample them at any point during WAIT.
- `rsp_data`, `rsp_status` and `rsp_err` hold their values until the next capture.
- `fpu_done` outside WAIT is ignored; it is never buffered.
- `req_valid` from non-granted requesters has no effect outside IDLE.
- A requester that drops `req_valid` before `req_ready` simply loses its turn.
- Fairness: with all requesters permanently valid, grants rotate 0,1,2,…,N_REQ-1,0.

## Timing
- Reset values:
  - FSM = IDLE; `last_grant` = N_REQ-1, so requester 0 wins first.
  - `req_ready`, `rsp_valid`, `fpu_start`, `busy`, `rsp_err` = 0.
  - `fpu_op_a`, `fpu_op_b`, `rsp_data` = 0; `rsp_status` = EXACT.
- Throughput and latency:
  - Accept edge T. `fpu_start` is high in cycle T+1.
  - If `fpu_done` arrives in cycle T+1+L (L ≥ 1), `rsp_valid` is high in cycle T+2+L.
  - The next `req_ready` can occur at the earliest in cycle T+3+L.
  - Minimum request-to-response time is L+2 cycles; one operation is in flight at a time.
- Reset asserted mid-operation: immediate return to IDLE, all outputs to reset values, the in-flight result is discarded, and no `rsp_valid` is issued.

## Configuration
- `FPU_ARB_TIMEOUT_EN` defined:
  - WAIT exits to RESPOND when the counter reaches `TIMEOUT-1` without `fpu_done`.
  - The response carries `rsp_data`=0, `rsp_status`=OVERFLOW, `rsp_err`=1.
  - A `fpu_done` arriving later is ignored, because the FSM is no longer in WAIT.
- Not defined: the counter and `rsp_err` logic are removed, `rsp_err` is tied to 0, and WAIT lasts indefinitely.

## Structure
- The shared package `fpu_pkg` holds:
  - `status_t`;
  - the arbiter state enum `arb_state_t`;
  - localparams for the field slices (SIGN_BIT=31, EXP_MSB=30, EXP_LSB=21, MANT_W=21).
- One sub-module, `rr_pick`: combinational round-robin grant over N_REQ, with inputs `req`/`last_grant` and outputs `grant_onehot`/`grant_idx`/`any`.

## Test plan
The bench uses a behavioural core model with fixed L=5 unless stated otherwise.
- Single request: reset, then `req_valid[0]` with A=0x3FE00000 (1.0) and B=0x3FE00000. Expect `req_ready[0]` in the first cycle, `fpu_start` one cycle later, and `rsp_valid[0]` 7 cycles after accept with `rsp_data`=0x40000000 and `rsp_status`=EXACT.
- Fairness: all 4 `req_valid` held high for 8 operations. Expect grant order 0,1,2,3,0,1,2,3, with exactly one `rsp_valid` bit per response, always matching the grant.
- Stability: the core model samples operands only on the cycle of `fpu_done`. Requesters change their inputs after accept. Expect the result to match the originally accepted A/B.
- Spurious done: `fpu_done` pulsed during IDLE and during ISSUE. Expect no state change and no `rsp_valid`.
- Reset mid-WAIT: reset asserted 2 cycles after `fpu_start`. Expect all outputs at reset values, no `rsp_valid`, and requester 0 granted first afterwards.
- Timeout (`FPU_ARB_TIMEOUT_EN`, TIMEOUT=8): the core never asserts done. Expect `rsp_valid` with `rsp_err`=1, `rsp_data`=0 and `rsp_status`=OVERFLOW. A late `fpu_done` must be ignored.
